// File: rtl/constraint_layer_mac_pipe_pkg.sv
// constraint_layer_mac_pkg: shared constants, stage control record and saturation bounds for the MAC pipe
package constraint_layer_mac_pkg;
  localparam int NUM_STAGE_MIN = 1;
  localparam int NUM_STAGE_MAX = 4;
  typedef struct packed {
    logic valid;
    logic last;
  } stage_ctl_t;
  function automatic logic signed [63:0] acc_max(input int w);
    return (64'sd1 <<< (w - 1)) - 64'sd1;
  endfunction
  function automatic logic signed [63:0] acc_min(input int w);
    return -(64'sd1 <<< (w - 1));
  endfunction
endpackage

// File: rtl/constraint_layer_mac_pipe_if.sv
// constraint_layer_mac_pipe_if: beat input and result output handshake bundle
// master drives beats and out_ready; slave (the MAC) drives in_ready and the result
interface constraint_layer_mac_pipe_if #(
  parameter int DIN0_WIDTH = 14,
  parameter int DIN1_WIDTH = 12,
  parameter int ACC_WIDTH  = 32
);
  logic                         in_valid;
  logic                         in_ready;
  logic                         in_last;
  logic signed [DIN0_WIDTH-1:0] din0;
  logic signed [DIN1_WIDTH-1:0] din1;
  logic                         out_valid;
  logic                         out_ready;
  logic signed [ACC_WIDTH-1:0]  dout;
  logic                         ovf;
  modport master (
    output in_valid, in_last, din0, din1, out_ready,
    input  in_ready, out_valid, dout, ovf
  );
  modport slave (
    input  in_valid, in_last, din0, din1, out_ready,
    output in_ready, out_valid, dout, ovf
  );
endinterface

// File: rtl/constraint_layer_mac_pipe_mulpipe.sv
// constraint_layer_mac_mulpipe: signed product followed by a NUM_STAGE-deep register chain
// ports: clk/rst, en_i (advance), valid_i/last_i/din0_i/din1_i in, valid_o/last_o/product_o from the tail stage
module constraint_layer_mac_mulpipe
  import constraint_layer_mac_pkg::*;
#(
  parameter int DIN0_WIDTH = 14,
  parameter int DIN1_WIDTH = 12,
  parameter int NUM_STAGE  = 2,
  localparam int PROD_WIDTH = DIN0_WIDTH + DIN1_WIDTH
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en_i,
  input  logic                         valid_i,
  input  logic                         last_i,
  input  logic signed [DIN0_WIDTH-1:0] din0_i,
  input  logic signed [DIN1_WIDTH-1:0] din1_i,
  output logic                         valid_o,
  output logic                         last_o,
  output logic signed [PROD_WIDTH-1:0] product_o
);
  typedef struct packed {
    stage_ctl_t                   ctl;
    logic signed [PROD_WIDTH-1:0] product;
  } stage_t;
  stage_t stage_q [NUM_STAGE];
  stage_t head_d;
  assign head_d = {valid_i, last_i, PROD_WIDTH'(din0_i) * PROD_WIDTH'(din1_i)};
  always_ff @(posedge clk)
    if (rst) begin
      for (int i = 0; i < NUM_STAGE; i++) stage_q[i] <= '0;
    end else if (en_i) begin
      stage_q[0] <= head_d;
      for (int i = 1; i < NUM_STAGE; i++) stage_q[i] <= stage_q[i-1];
    end
  assign valid_o   = stage_q[NUM_STAGE-1].ctl.valid;
  assign last_o    = stage_q[NUM_STAGE-1].ctl.last;
  assign product_o = stage_q[NUM_STAGE-1].product;
endmodule

// File: rtl/constraint_layer_mac_pipe.sv
// constraint_layer_mac_pipe: streaming signed dot-product unit with valid/ready on both sides
// ports: ap_clk, ap_rst (sync, active high), bus (slave modport: beats in, accumulated result out)
// build option: CONSTRAINT_LAYER_MAC_SAT_EN makes each addition saturate and reports it on ovf
module constraint_layer_mac_pipe
  import constraint_layer_mac_pkg::*;
#(
  parameter int DIN0_WIDTH = 14,
  parameter int DIN1_WIDTH = 12,
  parameter int ACC_WIDTH  = 32,
  parameter int NUM_STAGE  = 2
) (
  input logic                        ap_clk,
  input logic                        ap_rst,
  constraint_layer_mac_pipe_if.slave bus
);
  localparam int PROD_WIDTH = DIN0_WIDTH + DIN1_WIDTH;
  if (NUM_STAGE < NUM_STAGE_MIN || NUM_STAGE > NUM_STAGE_MAX) begin : g_bad_num_stage
    $error("NUM_STAGE must be within 1..4");
  end
  if (ACC_WIDTH < PROD_WIDTH) begin : g_bad_acc_width
    $error("ACC_WIDTH must hold a full product");
  end
  logic                         adv, take, close;
  logic                         tail_valid, tail_last;
  logic signed [PROD_WIDTH-1:0] tail_product;
  logic signed [ACC_WIDTH-1:0]  base, addend, sum;
  logic signed [ACC_WIDTH-1:0]  acc_q, acc_d, dout_q, dout_d;
  logic                         out_valid_q, out_valid_d, first_q, first_d;
  // a stalled result freezes the whole pipe, so one enable serves every stage
  assign adv          = !out_valid_q || bus.out_ready;
  assign bus.in_ready = adv;
  constraint_layer_mac_mulpipe #(
    .DIN0_WIDTH(DIN0_WIDTH),
    .DIN1_WIDTH(DIN1_WIDTH),
    .NUM_STAGE (NUM_STAGE)
  ) u_mulpipe (
    .clk      (ap_clk),
    .rst      (ap_rst),
    .en_i     (adv),
    .valid_i  (bus.in_valid),
    .last_i   (bus.in_last),
    .din0_i   (bus.din0),
    .din1_i   (bus.din1),
    .valid_o  (tail_valid),
    .last_o   (tail_last),
    .product_o(tail_product)
  );
  assign take   = adv && tail_valid;
  assign close  = take && tail_last;
  assign base   = first_q ? '0 : acc_q;
  assign addend = ACC_WIDTH'(tail_product);
`ifdef CONSTRAINT_LAYER_MAC_SAT_EN
  localparam int AW1 = ACC_WIDTH + 1;
  localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = ACC_WIDTH'(acc_max(ACC_WIDTH));
  localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = ACC_WIDTH'(acc_min(ACC_WIDTH));
  logic signed [ACC_WIDTH:0] wide;
  logic                      sat, sat_any, sat_q, sat_d, ovf_q, ovf_d;
  // one guard bit: overflow shows as disagreement between the top two bits
  assign wide    = AW1'(base) + AW1'(addend);
  assign sat     = wide[ACC_WIDTH] != wide[ACC_WIDTH-1];
  assign sum     = !sat ? wide[ACC_WIDTH-1:0] : wide[ACC_WIDTH] ? ACC_MIN : ACC_MAX;
  assign sat_any = sat_q || sat;
  assign sat_d   = take ? !tail_last && sat_any : sat_q;
  assign ovf_d   = close ? sat_any : ovf_q;
  assign bus.ovf = ovf_q;
  always_ff @(posedge ap_clk)
    if (ap_rst) begin
      sat_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      sat_q <= sat_d;
      ovf_q <= ovf_d;
    end
`else
  assign sum     = base + addend;
  assign bus.ovf = 1'b0;
`endif
  assign acc_d       = take ? (tail_last ? '0 : sum) : acc_q;
  assign first_d     = take ? tail_last : first_q;
  assign dout_d      = close ? sum : dout_q;
  assign out_valid_d = adv ? close : out_valid_q;
  always_ff @(posedge ap_clk)
    if (ap_rst) begin
      acc_q       <= '0;
      first_q     <= 1'b1;
      dout_q      <= '0;
      out_valid_q <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      first_q     <= first_d;
      dout_q      <= dout_d;
      out_valid_q <= out_valid_d;
    end
  assign bus.out_valid = out_valid_q;
  assign bus.dout      = dout_q;
endmodule
